instr_exec_sequencer: RTL and testbench

- Sequences execution of a block of stored instructions: walks a contiguous address range of the instruction register storage, fetches each instruction_t (opc, op_a, op_b) and computes its result.
- Writes the 64-bit result back into the same entry.
- Sits between the testbench/host control interface and the instruction register storage; it is the only master of the storage read and result-write ports while busy.

---
 rtl/instr_exec_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_instr_exec_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_exec_sequencer.sv
// Instruction block sequencer: walks a contiguous, wrapping range of the
// instruction storage, fetches each (opc, op_a, op_b) entry, evaluates it
// and writes the 64-bit result back into the same entry.
//
// Opcode encoding:
//   0 ZERO, 1 PASSA, 2 PASSB, 3 ADD, 4 SUB, 5 MULT, 6 DIV, 7 MOD, 8 POW.
//   Opcodes 9..15 are illegal. They produce 0 and set the sticky illegal_op flag.
//
// POW uses square-and-multiply and needs one EXEC cycle per significant
// exponent bit. Every other opcode finishes in a single EXEC cycle.
module instr_exec_sequencer #(
    parameter int NUM_ENTRIES = 32,
    parameter int OPERAND_W   = 32,
    parameter int RESULT_W    = 64
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 start,
    input  logic [$clog2(NUM_ENTRIES)-1:0]       start_addr,
    input  logic [$clog2(NUM_ENTRIES):0]         count,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 illegal_op,
    output logic                                 rd_en,
    output logic [$clog2(NUM_ENTRIES)-1:0]       rd_addr,
    input  logic [3:0]                           rd_opc,
    input  logic signed [OPERAND_W-1:0]          rd_op_a,
    input  logic signed [OPERAND_W-1:0]          rd_op_b,
    output logic                                 wr_en,
    output logic [$clog2(NUM_ENTRIES)-1:0]       wr_addr,
    output logic signed [RESULT_W-1:0]           wr_result
);

    localparam int AW = $clog2(NUM_ENTRIES);
    localparam int CW = AW + 1;

    localparam logic [3:0] OPC_ZERO  = 4'd0;
    localparam logic [3:0] OPC_PASSA = 4'd1;
    localparam logic [3:0] OPC_PASSB = 4'd2;
    localparam logic [3:0] OPC_ADD   = 4'd3;
    localparam logic [3:0] OPC_SUB   = 4'd4;
    localparam logic [3:0] OPC_MULT  = 4'd5;
    localparam logic [3:0] OPC_DIV   = 4'd6;
    localparam logic [3:0] OPC_MOD   = 4'd7;
    localparam logic [3:0] OPC_POW   = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_EXEC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state, state_d;

    // Control state. These registers are reset.
    logic [AW-1:0]                ptr;
    logic [CW-1:0]                remaining;
    logic signed [RESULT_W-1:0]   acc_q;
    logic signed [RESULT_W-1:0]   base_q;
    logic [OPERAND_W-1:0]         e_q;

    // Captured instruction and result. These registers are not reset, because
    // they are only observed after the FSM has loaded them.
    logic [3:0]                   opc_q;
    logic signed [OPERAND_W-1:0]  a_q;
    logic signed [OPERAND_W-1:0]  b_q;
    logic signed [RESULT_W-1:0]   result_q;

    // Combinational datapath.
    logic signed [RESULT_W-1:0]   a_ext;
    logic signed [RESULT_W-1:0]   b_ext;
    logic signed [RESULT_W-1:0]   acc_mul;
    logic signed [RESULT_W-1:0]   base_sq;
    logic signed [RESULT_W-1:0]   acc_step;
    logic [OPERAND_W-1:0]         e_step;
    logic signed [RESULT_W-1:0]   exec_result;
    logic                         pow_active;
    logic                         exec_last;

    // Evaluates every single-cycle opcode. POW is handled by the iterative
    // path. A division by zero yields 0 and is not flagged.
    function automatic logic signed [RESULT_W-1:0] alu_op(
        input logic [3:0]                 opc,
        input logic signed [RESULT_W-1:0] a,
        input logic signed [RESULT_W-1:0] b
    );
        logic signed [RESULT_W-1:0] r;
        r = '0;
        case (opc)
            OPC_ZERO:  r = '0;
            OPC_PASSA: r = a;
            OPC_PASSB: r = b;
            OPC_ADD:   r = a + b;
            OPC_SUB:   r = a - b;
            OPC_MULT:  r = a * b;
            OPC_DIV:   if (b != '0) r = a / b;
            OPC_MOD:   if (b != '0) r = a % b;
            default:   r = '0;
        endcase
        return r;
    endfunction

    function automatic logic is_illegal(input logic [3:0] opc);
        return opc > OPC_POW;
    endfunction

    // Advances the entry pointer and wraps it at the last entry.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        logic [AW-1:0] n;
        if (p == AW'(NUM_ENTRIES - 1)) n = '0;
        else                           n = p + AW'(1);
        return n;
    endfunction

    assign a_ext    = {{(RESULT_W-OPERAND_W){a_q[OPERAND_W-1]}}, a_q};
    assign b_ext    = {{(RESULT_W-OPERAND_W){b_q[OPERAND_W-1]}}, b_q};
    assign acc_mul  = acc_q * base_q;
    assign base_sq  = base_q * base_q;
    assign acc_step = e_q[0] ? acc_mul : acc_q;
    assign e_step   = e_q >> 1;

    // Selects the EXEC result and decides whether EXEC finishes this cycle.
    always_comb begin
        pow_active  = (opc_q == OPC_POW) && !b_q[OPERAND_W-1];
        exec_last   = !pow_active || (e_step == '0);
        exec_result = alu_op(opc_q, a_ext, b_ext);
        if (pow_active) exec_result = acc_step;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_d;
    end

    // FSM next-state logic. A start request is honoured only in IDLE.
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (count != '0) state_d = S_FETCH;
                    else             state_d = S_DONE;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD:  state_d = S_EXEC;
            S_EXEC:  if (exec_last) state_d = S_WRITE;
            S_WRITE: begin
                if (remaining == CW'(1)) state_d = S_DONE;
                else                     state_d = S_FETCH;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs. The buses are held at zero outside their strobe cycles.
    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        rd_en     = 1'b0;
        rd_addr   = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_result = '0;
        if (state == S_FETCH) begin
            rd_en   = 1'b1;
            rd_addr = ptr;
        end
        if (state == S_WRITE) begin
            wr_en     = 1'b1;
            wr_addr   = ptr;
            wr_result = result_q;
        end
    end

    // Block bookkeeping, the sticky illegal flag and the POW iteration state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr        <= '0;
            remaining  <= '0;
            illegal_op <= 1'b0;
            acc_q      <= '0;
            base_q     <= '0;
            e_q        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        illegal_op <= 1'b0;
                        if (count != '0) begin
                            ptr       <= start_addr;
                            remaining <= count;
                        end
                    end
                end
                S_LOAD: begin
                    acc_q  <= RESULT_W'(1);
                    base_q <= {{(RESULT_W-OPERAND_W){rd_op_a[OPERAND_W-1]}}, rd_op_a};
                    e_q    <= rd_op_b;
                end
                S_EXEC: begin
                    if (is_illegal(opc_q)) illegal_op <= 1'b1;
                    if (pow_active) begin
                        acc_q  <= acc_step;
                        base_q <= base_sq;
                        e_q    <= e_step;
                    end
                end
                S_WRITE: begin
                    ptr       <= ptr_inc(ptr);
                    remaining <= remaining - CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Captures the fetched instruction and latches the EXEC result.
    always_ff @(posedge clk) begin
        if (state == S_LOAD) begin
            opc_q <= rd_opc;
            a_q   <= rd_op_a;
            b_q   <= rd_op_b;
        end
        if (state == S_EXEC) result_q <= exec_result;
    end

endmodule

// File: tb/tb_instr_exec_sequencer.sv
// Scoreboard bench for instr_exec_sequencer. Stimulus pushes the expected
// writes (address, value, cycle) and done pulses. A monitor on the falling
// edge pops the queues and compares them against what the DUT presents.
module tb_instr_exec_sequencer;

    localparam logic [3:0] ZERO = 4'd0, PASSA = 4'd1, PASSB = 4'd2, ADD = 4'd3,
                           SUB = 4'd4, MULT = 4'd5, DIV = 4'd6, MOD = 4'd7, POW = 4'd8;
    localparam logic [63:0] SENT = 64'hDEAD_BEEF_DEAD_BEEF;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               start;
    logic [4:0]         start_addr;
    logic [5:0]         count;
    logic               busy, done, illegal_op, rd_en, wr_en;
    logic [4:0]         rd_addr, wr_addr;
    logic [3:0]         rd_opc = '0;
    logic signed [31:0] rd_op_a = '0, rd_op_b = '0;
    logic signed [63:0] wr_result;

    instr_exec_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
        .count(count), .busy(busy), .done(done), .illegal_op(illegal_op),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_opc(rd_opc), .rd_op_a(rd_op_a),
        .rd_op_b(rd_op_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_result(wr_result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Storage model: the read data is registered, and results land in m_res.
    logic [3:0]         m_opc [32];
    logic signed [31:0] m_a   [32];
    logic signed [31:0] m_b   [32];
    logic [63:0]        m_res [32];
    int rd_cnt = 0, wr_cnt = 0;
    always @(posedge clk) begin
        if (rd_en) begin
            rd_opc  <= m_opc[rd_addr];
            rd_op_a <= m_a[rd_addr];
            rd_op_b <= m_b[rd_addr];
            rd_cnt  = rd_cnt + 1;
        end
        if (wr_en) begin
            m_res[wr_addr] = wr_result;
            wr_cnt = wr_cnt + 1;
        end
    end

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    typedef struct {
        int          addr;
        logic [63:0] res;
        int          at;
    } wr_exp_t;

    wr_exp_t wq[$];
    int      dq[$];
    wr_exp_t mon_e;
    int      mon_d;
    int      acc_cyc;

    task automatic exp_wr(input int addr, input logic [63:0] res, input int at);
        wr_exp_t x;
        x.addr = addr; x.res = res; x.at = at;
        wq.push_back(x);
    endtask

    // Compares each write and done pulse against the front of its queue.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (wr_en) begin
                if (wq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_wr actual addr=%0d required=no write", wr_addr);
                end else begin
                    mon_e = wq.pop_front();
                    chk("wr_addr", 64'(wr_addr), 64'(mon_e.addr));
                    chk("wr_result", wr_result, mon_e.res);
                    chk("wr_cycle", 64'(cyc), 64'(mon_e.at));
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_done actual cycle=%0d required=no done", cyc);
                end else begin
                    mon_d = dq.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(mon_d));
                end
            end
        end
    end

    task automatic set_e(input int i, input logic [3:0] o, input logic signed [31:0] a,
                         input logic signed [31:0] b);
        m_opc[i] = o; m_a[i] = a; m_b[i] = b;
    endtask

    // Presents start for one cycle. acc_cyc is the cycle in which it is sampled.
    task automatic kick(input logic [4:0] sa, input logic [5:0] cnt);
        @(negedge clk);
        acc_cyc = cyc; start = 1'b1; start_addr = sa; count = cnt;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_blk(input string name);
        for (int i = 0; i < 300 && (wq.size() != 0 || dq.size() != 0); i++) @(negedge clk);
        if (wq.size() != 0 || dq.size() != 0) begin
            checks++; failures++;
            $display("FAIL timeout_%s actual pending=%0d required=0", name, wq.size() + dq.size());
            wq.delete(); dq.delete();
        end
        @(negedge clk);
    endtask

    int rd0, wr0;

    initial begin
        reset_n = 1'b0; start = 1'b0; start_addr = '0; count = '0;
        for (int i = 0; i < 32; i++) begin
            m_opc[i] = ZERO; m_a[i] = 0; m_b[i] = 0; m_res[i] = SENT;
        end
        set_e(3,  ADD,  5, -7);
        set_e(10, MULT, -3, 4);  set_e(11, DIV, 7, -2);  set_e(12, MOD, -7, 2);
        set_e(14, DIV,  9, 0);   set_e(15, MOD, 9, 0);
        set_e(16, DIV,  32'sh8000_0000, -1);             set_e(17, SUB, 3, 10);
        set_e(20, POW,  3, 5);   set_e(21, POW, 2, 0);   set_e(22, POW, 2, -1);
        set_e(23, POW,  2, 63);  set_e(24, POW, 2, 64);
        set_e(30, ADD,  1, 2);   set_e(31, 4'd12, 6, 7);
        set_e(0,  PASSA, -5, 9); set_e(1, PASSB, 4, -9);
        for (int i = 4; i < 8; i++) set_e(i, PASSA, 11 + i, 1);

        repeat (3) @(negedge clk);
        chk("reset_ctrl", 64'({busy, done, illegal_op, rd_en, wr_en}), 64'd0);
        chk("reset_addr", 64'({rd_addr, wr_addr}), 64'd0);
        chk("reset_result", wr_result, 64'd0);
        reset_n = 1'b1;

        // Single ADD: write four cycles after accept, done on the next cycle.
        kick(5'd3, 6'd1);
        exp_wr(3, -2, acc_cyc + 4);
        dq.push_back(acc_cyc + 5);
        wait_blk("add");

        // Mixed block, plus a competing start while busy that must be ignored.
        rd0 = rd_cnt;
        kick(5'd10, 6'd3);
        exp_wr(10, -12, acc_cyc + 4);
        exp_wr(11, -3,  acc_cyc + 8);
        exp_wr(12, -1,  acc_cyc + 12);
        dq.push_back(acc_cyc + 13);
        repeat (4) @(negedge clk);
        start = 1'b1; start_addr = 5'd0; count = 6'd5;
        @(negedge clk);
        start = 1'b0;
        wait_blk("mixed");
        chk("mixed_reads", 64'(rd_cnt - rd0), 64'd3);

        // Division by zero, the most-negative division case, and SUB.
        kick(5'd14, 6'd4);
        exp_wr(14, 0, acc_cyc + 4);
        exp_wr(15, 0, acc_cyc + 8);
        exp_wr(16, 64'h0000_0000_8000_0000, acc_cyc + 12);
        exp_wr(17, -7, acc_cyc + 16);
        dq.push_back(acc_cyc + 17);
        wait_blk("divzero");
        chk("divzero_illegal", 64'(illegal_op), 64'd0);

        // POW: each entry takes 3 cycles plus its EXEC iteration count (3,1,1,6,7).
        kick(5'd20, 6'd5);
        exp_wr(20, 243, acc_cyc + 6);
        exp_wr(21, 1,   acc_cyc + 10);
        exp_wr(22, 0,   acc_cyc + 14);
        exp_wr(23, 64'h8000_0000_0000_0000, acc_cyc + 23);
        exp_wr(24, 0,   acc_cyc + 33);
        dq.push_back(acc_cyc + 34);
        wait_blk("pow");

        // Address wrap 30,31,0,1 with an illegal opcode at 31.
        kick(5'd30, 6'd4);
        exp_wr(30, 3,  acc_cyc + 4);
        exp_wr(31, 0,  acc_cyc + 8);
        exp_wr(0,  -5, acc_cyc + 12);
        exp_wr(1,  -9, acc_cyc + 16);
        dq.push_back(acc_cyc + 17);
        wait_blk("wrap");
        chk("wrap_illegal", 64'(illegal_op), 64'd1);

        // Empty block: done next cycle, no storage traffic, flag cleared.
        rd0 = rd_cnt; wr0 = wr_cnt;
        kick(5'd7, 6'd0);
        dq.push_back(acc_cyc + 1);
        wait_blk("empty");
        chk("empty_reads", 64'(rd_cnt - rd0), 64'd0);
        chk("empty_writes", 64'(wr_cnt - wr0), 64'd0);
        chk("empty_illegal", 64'(illegal_op), 64'd0);

        // Reset during EXEC of the first entry of a four-entry block.
        wr0 = wr_cnt;
        kick(5'd4, 6'd4);
        repeat (2) @(negedge clk);
        chk("pre_reset_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_ctrl", 64'({busy, done, illegal_op, rd_en, wr_en}), 64'd0);
        chk("abort_addr", 64'({rd_addr, wr_addr}), 64'd0);
        chk("abort_result", wr_result, 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_writes", 64'(wr_cnt - wr0), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("kept_entry3", m_res[3], -64'sd2);
        chk("kept_entry4", m_res[4], SENT);
        chk("queues_drained", 64'(wq.size() + dq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
